// File: rtl/pht_update_queue_pkg.sv
// Shared fetch-unit types for the PHT update path.
// Branch result record, PHT index/entry paths, queue entry and helpers.
package pht_update_queue_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int INSN_ADDR_BIT_WIDTH = 2;
  localparam int PHT_ENTRY_NUM_BIT_WIDTH = 10;
  localparam int PHT_ENTRY_WIDTH = 2;
  localparam int BRANCH_GLOBAL_HISTORY_BIT_WIDTH = 8;
  localparam int PHT_QUEUE_SIZE = 32;
  localparam int PHT_QUEUE_SIZE_BIT_WIDTH = $clog2(PHT_QUEUE_SIZE);

  typedef logic [ADDR_WIDTH-1:0] PC_Path;
  typedef logic [BRANCH_GLOBAL_HISTORY_BIT_WIDTH-1:0]
    BranchGlobalHistoryPath;
  typedef logic [PHT_ENTRY_NUM_BIT_WIDTH-1:0] PHT_IndexPath;
  typedef logic [PHT_ENTRY_WIDTH-1:0] PHT_EntryPath;

  // Extra MSB is the wrap bit that separates full from empty.
  typedef logic [PHT_QUEUE_SIZE_BIT_WIDTH:0] PhtQueuePointerPath;

  localparam PHT_EntryPath PHT_ENTRY_MAX = '1;
  localparam PHT_EntryPath PHT_ENTRY_MIN = '0;

  typedef struct packed {
    logic valid;
    logic isCondBr;
    logic execTaken;
    PC_Path pc;
    BranchGlobalHistoryPath globalHistory;
    PHT_EntryPath phtPrevValue;
  } BranchResult;

  typedef struct packed {
    PHT_IndexPath phtWA;
    PHT_EntryPath phtWV;
  } PhtUpdateEntry;

  // gshare index: word-aligned PC bits XOR history in the low bits.
  function automatic PHT_IndexPath ToPHT_Index(
    input PC_Path pc,
    input BranchGlobalHistoryPath gh
  );
    PHT_IndexPath idx;
    idx = pc[INSN_ADDR_BIT_WIDTH +: PHT_ENTRY_NUM_BIT_WIDTH];
    idx = idx ^ PHT_IndexPath'(gh);
    return idx;
  endfunction

  // 2-bit saturating counter step.
  function automatic PHT_EntryPath NextPhtValue(
    input logic taken,
    input PHT_EntryPath prev
  );
    PHT_EntryPath nv;
    if (taken) begin
      nv = (prev == PHT_ENTRY_MAX) ? prev : prev + PHT_EntryPath'(1);
    end else begin
      nv = (prev == PHT_ENTRY_MIN) ? prev : prev - PHT_EntryPath'(1);
    end
    return nv;
  endfunction

endpackage

// File: rtl/pht_update_fifo.sv
// Circular buffer of PHT updates with wrap-bit pointers.
// Ports: clk, rst, push/pushData, pop, headData, full, empty.
module pht_update_fifo
  import pht_update_queue_pkg::*;
#(
  parameter int QUEUE_SIZE = PHT_QUEUE_SIZE
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  PhtUpdateEntry pushData,
  input  logic          pop,
  output PhtUpdateEntry headData,
  output logic          full,
  output logic          empty
);

  localparam int IW = $clog2(QUEUE_SIZE);

  typedef logic [IW:0] PtrPath;

  PtrPath headPtr;
  PtrPath tailPtr;

  // Storage has no reset; contents are only read behind headPtr.
  PhtUpdateEntry body [QUEUE_SIZE];

  // The caller qualifies push and pop against full/empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      headPtr <= '0;
      tailPtr <= '0;
    end else begin
      if (push) tailPtr <= tailPtr + PtrPath'(1);
      if (pop) headPtr <= headPtr + PtrPath'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) body[tailPtr[IW-1:0]] <= pushData;
  end

  always_comb begin
    headData = body[headPtr[IW-1:0]];
    empty = (headPtr == tailPtr);
    full = (headPtr[IW-1:0] == tailPtr[IW-1:0]) &&
           (headPtr[IW] != tailPtr[IW]);
  end

endmodule

// File: rtl/pht_update_queue.sv
// Buffers PHT counter updates and drains them into the PHT write port.
// Ports: clk, rst, brResult, portBusy, phtWE/WA/WV, full, empty, dropCount.
module pht_update_queue
  import pht_update_queue_pkg::*;
#(
  parameter int QUEUE_SIZE = PHT_QUEUE_SIZE,
  parameter int DROP_COUNT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  BranchResult                 brResult,
  input  logic                        portBusy,
  output logic                        phtWE,
  output PHT_IndexPath                phtWA,
  output PHT_EntryPath                phtWV,
  output logic                        full,
  output logic                        empty,
  output logic [DROP_COUNT_WIDTH-1:0] dropCount
);

  typedef logic [DROP_COUNT_WIDTH-1:0] DropCountPath;

  logic          pushReq;
  logic          pushFire;
  logic          popFire;
  logic          dropEvent;
  PhtUpdateEntry pushEntry;
  PhtUpdateEntry headEntry;

  always_comb begin
    pushReq = brResult.valid && brResult.isCondBr;
    // Pop depends only on registered state and portBusy.
    popFire = !empty && !portBusy;
    // A full queue still accepts when the head leaves this cycle.
    pushFire = pushReq && (!full || popFire);
    dropEvent = pushReq && !pushFire;
    pushEntry.phtWA = ToPHT_Index(brResult.pc, brResult.globalHistory);
    pushEntry.phtWV = NextPhtValue(
      brResult.execTaken,
      brResult.phtPrevValue
    );
  end

  pht_update_fifo #(
    .QUEUE_SIZE(QUEUE_SIZE)
  ) fifo (
    .clk(clk),
    .rst(rst),
    .push(pushFire),
    .pushData(pushEntry),
    .pop(popFire),
    .headData(headEntry),
    .full(full),
    .empty(empty)
  );

  always_comb begin
    phtWE = popFire;
    phtWA = headEntry.phtWA;
    phtWV = headEntry.phtWV;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dropCount <= '0;
    end else if (dropEvent && (dropCount != '1)) begin
      dropCount <= dropCount + DropCountPath'(1);
    end
  end

endmodule
